// File: rtl/fpu_pkg.sv
// Types and constants shared by the FPU issue logic and its clients.
package fpu_pkg;

  localparam int FADD_LAT = 2;
  // Widest requester id any shared FPU unit carries in its in-flight tags.
  localparam int ID_MAX_W = 8;

  typedef enum logic {
    FOP_ADD = 1'b0,
    FOP_SUB = 1'b1
  } fop_e;

  typedef logic [31:0] flt_t;

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
  } inflight_t;

endpackage

// File: rtl/fadd_pipe.sv
// Two-stage IEEE-754 single-precision adder (round to nearest even); c is valid two edges after a/b.
module fadd_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] c
);

  logic [31:0] a_q, b_q, c_q;

  function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] big, sml;
    logic [7:0]  eb, es, d;
    logic [8:0]  e;
    logic [26:0] mb, ms, m;
    logic [27:0] sum;
    logic [24:0] mant;
    logic        xnan, ynan, rnd;
    xnan = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    ynan = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
    if (xnan || ynan) return 32'h7FC0_0000;
    if (x[30:23] == 8'hFF && y[30:23] == 8'hFF)
      return (x[31] != y[31]) ? 32'h7FC0_0000 : x;
    if (x[30:23] == 8'hFF) return x;
    if (y[30:23] == 8'hFF) return y;

    if (x[30:0] >= y[30:0]) begin big = x; sml = y; end
    else begin big = y; sml = x; end
    // Denormals behave as exponent 1 without the hidden bit.
    eb = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
    es = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
    mb = {big[30:23] != 8'd0, big[22:0], 3'b000};
    ms = {sml[30:23] != 8'd0, sml[22:0], 3'b000};
    d  = eb - es;
    if (d >= 8'd27) ms = {26'd0, |ms};
    else ms = (ms >> d) | {26'd0, |(ms & ((27'd1 << d) - 27'd1))};
    e = {1'b0, eb};

    if (x[31] == y[31]) begin
      sum = {1'b0, mb} + {1'b0, ms};
      if (sum[27]) begin
        sum = {1'b0, sum[27:2], sum[1] | sum[0]};
        e   = e + 9'd1;
      end
      m = sum[26:0];
    end else begin
      m = mb - ms;
      if (m == 27'd0) return 32'h0000_0000;
      for (int i = 0; i < 27; i++) begin
        if (!m[26] && e > 9'd1) begin
          m = m << 1;
          e = e - 9'd1;
        end
      end
    end

    rnd  = m[2] & (m[1] | m[0] | m[3]);
    mant = {1'b0, m[26:3]} + {24'd0, rnd};
    if (mant[24]) begin
      mant = mant >> 1;
      e    = e + 9'd1;
    end
    if (e >= 9'd255) return {big[31], 8'hFF, 23'd0};
    return {big[31], mant[23] ? e[7:0] : 8'd0, mant[22:0]};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
    end else begin
      a_q <= a;
      b_q <= b;
      c_q <= fp_add(a_q, b_q);
    end
  end

  assign c = c_q;

endmodule

// File: rtl/rr_grant.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap-around.
module rr_grant #(
  parameter int NREQ = 2,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] next_ptr
);

  int  idx;
  logic found;

  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        next_ptr   = ID_W'((idx + 1) % NREQ);
      end
    end
  end

endmodule

// File: rtl/fadd_issue_arbiter.sv
// Round-robin issue of add/sub requests into one shared fadd_pipe, with id tagging of results.
module fadd_issue_arbiter #(
  parameter int NREQ     = 2,
  parameter int FADD_LAT = 2,
  parameter int ID_W     = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ-1:0]    req_op,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  input  logic               flush,
  output logic               rsp_valid,
  output logic [ID_W-1:0]    rsp_id,
  output logic [31:0]        rsp_data,
  output logic               busy
);

  import fpu_pkg::*;

  flt_t                     a_arr [NREQ];
  flt_t                     b_arr [NREQ];
  logic [NREQ-1:0]          grant;
  logic [ID_W-1:0]          next_ptr, ptr_q, ptr_d, gnt_id;
  logic                     hs;
  flt_t                     a_q, a_d, b_q, b_d, c;
  inflight_t [FADD_LAT:0]   pipe_q, pipe_d;
  logic                     unused_id_bits;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign a_arr[gi] = req_a[32*gi +: 32];
      assign b_arr[gi] = req_b[32*gi +: 32];
    end
  endgenerate

  rr_grant #(.NREQ(NREQ), .ID_W(ID_W)) u_rr_grant (
    .req      (req_valid),
    .ptr      (ptr_q),
    .grant    (grant),
    .next_ptr (next_ptr)
  );

  assign req_ready = grant & {NREQ{~flush}};
  assign hs        = |req_ready;

  always_comb begin
    gnt_id = '0;
    for (int k = 0; k < NREQ; k++)
      if (grant[k]) gnt_id = ID_W'(k);
  end

  always_comb begin
    ptr_d = hs ? next_ptr : ptr_q;
    a_d   = a_q;
    b_d   = b_q;
    if (hs) begin
      a_d = a_arr[gnt_id];
      b_d = b_arr[gnt_id] ^ ((fop_e'(req_op[gnt_id]) == FOP_SUB) ? 32'h8000_0000 : 32'h0);
    end
    pipe_d[0].valid = hs;
    pipe_d[0].id    = hs ? ID_MAX_W'(gnt_id) : '0;
    for (int k = 1; k <= FADD_LAT; k++) pipe_d[k] = pipe_q[k-1];
    // fadd_pipe keeps running; clearing the tags alone masks its stale results.
    if (flush) pipe_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      pipe_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      a_q    <= a_d;
      b_q    <= b_d;
      pipe_q <= pipe_d;
    end
  end

  fadd_pipe u_fadd_pipe (
    .clk (clk),
    .rst (rst),
    .a   (a_q),
    .b   (b_q),
    .c   (c)
  );

  // A result landing in the flush cycle belongs to a killed operation.
  assign rsp_valid      = pipe_q[FADD_LAT].valid & ~flush;
  assign rsp_id         = pipe_q[FADD_LAT].id[ID_W-1:0];
  assign rsp_data       = c;
  assign unused_id_bits = ^pipe_q[FADD_LAT].id;

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k <= FADD_LAT; k++) busy = busy | pipe_q[k].valid;
  end

endmodule

// File: tb/tb_fadd_issue_arbiter.sv
// Directed scoreboard bench for fadd_issue_arbiter with two requesters.
module tb_fadd_issue_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, req_op;
  logic [63:0] req_a, req_b;
  logic        flush;
  logic        rsp_valid;
  logic [0:0]  rsp_id;
  logic [31:0] rsp_data;
  logic        busy;

  typedef struct {
    int          id;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   mptr     = 0;

  fadd_issue_arbiter #(.NREQ(2), .FADD_LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .flush     (flush),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Monitor: pop and compare whenever a response appears; flag late or missing ones.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      checks++;
      failures++;
      $display("FAIL missing_rsp cyc=%0d actual=none required=id%0d/%h@%0d",
               cyc, sb[0].id, sb[0].data, sb[0].cyc);
      void'(sb.pop_front());
    end
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp cyc=%0d actual=id%0d/%h required=none", cyc, rsp_id, rsp_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_cycle", cyc, e.cyc);
        chk("rsp_id", {31'd0, rsp_id}, e.id);
        chk("rsp_data", rsp_data, e.data);
        $display("rsp cyc=%0d id=%0d data=%h", cyc, rsp_id, rsp_data);
      end
    end
  end

  // One cycle of stimulus; the bench's own round-robin model predicts the grant.
  task automatic drive(input logic [1:0] v, input logic [1:0] op,
                       input logic [31:0] a0, input logic [31:0] b0, input logic [31:0] e0,
                       input logic [31:0] a1, input logic [31:0] b1, input logic [31:0] e1,
                       input logic fl);
    logic [1:0] exp_rdy;
    int g;
    req_valid = v;
    req_op    = op;
    req_a     = {a1, a0};
    req_b     = {b1, b0};
    flush     = fl;
    @(negedge clk);
    exp_rdy = 2'b00;
    g = -1;
    if (!fl) begin
      for (int i = 0; i < 2; i++) begin
        int k;
        k = (mptr + i) % 2;
        if (g < 0 && v[k]) g = k;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", {30'd0, req_ready}, {30'd0, exp_rdy});
    if (fl) sb.delete();
    if (g >= 0) begin
      sb.push_back('{id: g, data: (g == 0) ? e0 : e1, cyc: cyc + 1 + LAT});
      mptr = (g + 1) % 2;
    end
    $display("issue cyc=%0d valid=%b flush=%b ready=%b", cyc, v, fl, req_ready);
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic drain();
    req_valid = 2'b00;
    repeat (6) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
  endtask

  logic [31:0] va [6] = '{32'h3F80_0000, 32'h3FC0_0000, 32'h3F00_0000,
                          32'h4120_0000, 32'h42C8_0000, 32'h3F80_0000};
  logic [31:0] vb [6] = '{32'h4000_0000, 32'h3FC0_0000, 32'h3E80_0000,
                          32'hC080_0000, 32'h3F80_0000, 32'hBF80_0000};
  logic [31:0] ve [6] = '{32'h4040_0000, 32'h4040_0000, 32'h3F40_0000,
                          32'h40C0_0000, 32'h42CA_0000, 32'h0000_0000};

  initial begin
    rst = 1'b1;
    req_valid = 2'b00;
    req_op = 2'b00;
    req_a = '0;
    req_b = '0;
    flush = 1'b0;
    #12;
    chk("reset_req_ready", {30'd0, req_ready}, 0);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("reset_rsp_id", {31'd0, rsp_id}, 0);
    chk("reset_busy", {31'd0, busy}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single add from requester 0, busy across the pipeline.
    drive(2'b01, 2'b00, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 0, 0, 0, 1'b0);
    req_valid = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("busy_inflight", {31'd0, busy}, 1);
    end
    @(negedge clk);
    chk("busy_idle", {31'd0, busy}, 0);
    drain();

    // Subtracts from requester 1; b's sign flips into the operand register.
    drive(2'b10, 2'b10, 0, 0, 0, 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0);
    chk("a_reg_sub", dut.a_q, 32'h4040_0000);
    chk("b_reg_sub", dut.b_q, 32'hBF80_0000);
    drive(2'b10, 2'b10, 0, 0, 0, 32'h3F80_0000, 32'h3F00_0000, 32'h3F00_0000, 1'b0);
    drain();

    // Both requesting: alternating grants, four back-to-back responses.
    repeat (4) drive(2'b11, 2'b00, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4040_0000,
                     32'h3F00_0000, 32'h3E80_0000, 32'h3F40_0000, 1'b0);
    drain();

    // Six-deep stream from requester 0 alone.
    for (int i = 0; i < 6; i++) drive(2'b01, 2'b00, va[i], vb[i], ve[i], 0, 0, 0, 1'b0);
    drain();

    // Three ops, a flush with both requesting, then resume.
    repeat (3) drive(2'b11, 2'b00, 32'h4120_0000, 32'hC080_0000, 32'h40C0_0000,
                     32'h42C8_0000, 32'h3F80_0000, 32'h42CA_0000, 1'b0);
    drive(2'b11, 2'b00, 32'h4120_0000, 32'hC080_0000, 32'h40C0_0000,
          32'h42C8_0000, 32'h3F80_0000, 32'h42CA_0000, 1'b1);
    repeat (2) drive(2'b11, 2'b00, 32'h4120_0000, 32'hC080_0000, 32'h40C0_0000,
                     32'h42C8_0000, 32'h3F80_0000, 32'h42CA_0000, 1'b0);
    drain();

    // Reset with two ops in flight; pointer returns to requester 0.
    repeat (2) drive(2'b11, 2'b10, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000,
                     32'h4000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
    req_valid = 2'b00;
    rst = 1'b1;
    #1;
    chk("rst_req_ready", {30'd0, req_ready}, 0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("rst_rsp_id", {31'd0, rsp_id}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    sb.delete();
    mptr = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    repeat (2) drive(2'b11, 2'b10, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000,
                     32'h4000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
